// File: rtl/wb_cmd_master_if.sv
// Signal bundle for wb_cmd_master: command stream, response stream and Wishbone initiator bus.
// cmd and rsp are valid/ready: a beat transfers on the rising edge where valid and ready are both
// high; the producer holds valid and its payload stable until that edge, and ready may depend on nothing in the same cycle.
interface wb_cmd_master_if;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_we_i;
  logic [31:0] cmd_adr_i;
  logic [31:0] cmd_dat_i;
  logic [3:0]  cmd_sel_i;

  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;

  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_dat_o, rsp_err_o,
    input  rsp_ready_i,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_ack_i, wbm_dat_i
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_dat_o, rsp_err_o,
    output rsp_ready_i,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_ack_i, wbm_dat_i
  );
endinterface

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer initiator: one command in, one CYC/STB cycle out, one
// response (read data or timeout error) back. Every output is registered.
module wb_cmd_master #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_n_i,
  wb_cmd_master_if.master        bus,
  output logic [1:0]             dbg_state_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [1:0]      r_state;
  logic [TO_W-1:0] r_cnt;

  assign dbg_state_o = r_state;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      bus.cmd_ready_o <= 1'b1;
      bus.rsp_valid_o <= 1'b0;
      bus.rsp_dat_o   <= '0;
      bus.rsp_err_o   <= 1'b0;
      bus.wbm_cyc_o   <= 1'b0;
      bus.wbm_stb_o   <= 1'b0;
      bus.wbm_we_o    <= 1'b0;
      bus.wbm_sel_o   <= '0;
      bus.wbm_adr_o   <= '0;
      bus.wbm_dat_o   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid_i && bus.cmd_ready_o) begin
            bus.wbm_we_o    <= bus.cmd_we_i;
            bus.wbm_adr_o   <= bus.cmd_adr_i;
            bus.wbm_sel_o   <= bus.cmd_sel_i;
            bus.wbm_dat_o   <= bus.cmd_we_i ? bus.cmd_dat_i : 32'd0;
            bus.wbm_cyc_o   <= 1'b1;
            bus.wbm_stb_o   <= 1'b1;
            bus.cmd_ready_o <= 1'b0;
            r_cnt           <= '0;
            r_state         <= S_BUS;
          end
        end
        S_BUS: begin
          r_cnt <= r_cnt + 1'b1;
          // ACK takes priority over the timeout on the final permitted cycle.
          if (bus.wbm_ack_i) begin
            bus.wbm_cyc_o   <= 1'b0;
            bus.wbm_stb_o   <= 1'b0;
            bus.rsp_dat_o   <= bus.wbm_we_o ? 32'd0 : bus.wbm_dat_i;
            bus.rsp_err_o   <= 1'b0;
            bus.rsp_valid_o <= 1'b1;
            r_state         <= S_RESP;
          end else if (r_cnt == TO_LAST) begin
            bus.wbm_cyc_o   <= 1'b0;
            bus.wbm_stb_o   <= 1'b0;
            bus.rsp_dat_o   <= 32'd0;
            bus.rsp_err_o   <= 1'b1;
            bus.rsp_valid_o <= 1'b1;
            r_state         <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.rsp_valid_o && bus.rsp_ready_i) begin
            bus.rsp_valid_o <= 1'b0;
            bus.cmd_ready_o <= 1'b1;
            r_state         <= S_IDLE;
          end
        end
        default: begin
          r_state         <= S_IDLE;
          bus.cmd_ready_o <= 1'b1;
          bus.rsp_valid_o <= 1'b0;
          bus.wbm_cyc_o   <= 1'b0;
          bus.wbm_stb_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: directed vector table, hand-built corner sequences and random
// transactions scored against a transaction-level model.
module tb_wb_cmd_master;
  localparam int TIMEOUT = 8;
  localparam int W = 49;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          ack_k;     // BUS cycle index (0-based) carrying ACK; -1 = never
    logic [31:0] rdata;
    int          rsp_wait;  // cycles rsp_ready_i is held low
    logic        stray;     // ACK asserted while the response waits
    logic [15:0] exp_len;
    logic        exp_err;
    logic [31:0] exp_dat;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         n_cmp;
  int         n_err;
  logic [W-1:0] exp_q[$];
  vec_t       vecs[6];

  wb_cmd_master_if bus();

  wb_cmd_master #(.TIMEOUT(TIMEOUT), .TO_W(4)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .bus        (bus.master),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level reference: how long the bus cycle lasts and what comes back.
  function automatic logic [W-1:0] model(input logic we, input int k, input logic [31:0] rd);
    logic [15:0] len;
    logic        err;
    logic [31:0] d;
    if (k >= 0 && k < TIMEOUT) begin
      len = 16'(k + 1);
      err = 1'b0;
      d   = we ? 32'd0 : rd;
    end else begin
      len = 16'(TIMEOUT);
      err = 1'b1;
      d   = 32'd0;
    end
    return {err, d, len};
  endfunction

  task automatic drive_idle();
    bus.cmd_valid_i = 1'b0;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_adr_i   = '0;
    bus.cmd_dat_i   = '0;
    bus.cmd_sel_i   = '0;
    bus.rsp_ready_i = 1'b0;
    bus.wbm_ack_i   = 1'b0;
    bus.wbm_dat_i   = '0;
  endtask

  // Driver: one full command, bus and response exchange, scored against exp_q.
  task automatic run_txn(input vec_t v);
    int          g;
    int          len;
    logic [31:0] held_dat;
    logic        held_err;
    logic [W-1:0] exp;
    @(negedge clk);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = v.we;
    bus.cmd_adr_i   = v.adr;
    bus.cmd_dat_i   = v.dat;
    bus.cmd_sel_i   = v.sel;
    g = 0;
    while (!bus.cmd_ready_o && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("cmd_ready_wait", 64'(bus.cmd_ready_o), 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    len = 0;
    g   = 0;
    while (bus.wbm_cyc_o && g < 64) begin
      if (len == 0) begin
        check("bus_stb", 64'(bus.wbm_stb_o), 64'd1);
        check("bus_adr", 64'(bus.wbm_adr_o), 64'(v.adr));
        check("bus_we",  64'(bus.wbm_we_o),  64'(v.we));
        check("bus_sel", 64'(bus.wbm_sel_o), 64'(v.sel));
        check("bus_dat", 64'(bus.wbm_dat_o), 64'(v.we ? v.dat : 32'd0));
        check("cmd_ready_busy", 64'(bus.cmd_ready_o), 64'd0);
      end
      bus.wbm_ack_i = (len == v.ack_k);
      bus.wbm_dat_i = (len == v.ack_k) ? v.rdata : 32'($urandom);
      len++;
      g++;
      @(negedge clk);
    end
    bus.wbm_ack_i = 1'b0;
    check("bus_stb_drop", 64'(bus.wbm_stb_o), 64'd0);
    check("rsp_valid_rise", 64'(bus.rsp_valid_o), 64'd1);
    // scoreboard
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 64'd1, 64'd0);
    end else begin
      exp = exp_q.pop_front();
      check("rsp_triplet", 64'({bus.rsp_err_o, bus.rsp_dat_o, 16'(len)}), 64'(exp));
    end
    held_dat = bus.rsp_dat_o;
    held_err = bus.rsp_err_o;
    for (int i = 0; i < v.rsp_wait; i++) begin
      bus.wbm_ack_i = v.stray;
      @(negedge clk);
      check("rsp_hold_valid", 64'(bus.rsp_valid_o), 64'd1);
      check("rsp_hold_dat", 64'({bus.rsp_err_o, bus.rsp_dat_o}), 64'({held_err, held_dat}));
      check("rsp_hold_ready", 64'({bus.cmd_ready_o, bus.wbm_cyc_o}), 64'd0);
    end
    bus.wbm_ack_i   = 1'b0;
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    check("rsp_done", 64'({bus.rsp_valid_o, bus.cmd_ready_o}), 64'b01);
    check("rsp_keep", 64'({bus.rsp_err_o, bus.rsp_dat_o}), 64'({held_err, held_dat}));
  endtask

  initial begin
    vec_t v;
    n_cmp = 0;
    n_err = 0;
    vecs[0] = '{1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 0,  32'hAAAA_5555, 0, 1'b0, 16'd1, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 32'h3000_0000, 32'h0,         4'hF, 3,  32'h1234_5678, 0, 1'b0, 16'd4, 1'b0, 32'h1234_5678};
    vecs[2] = '{1'b0, 32'h3000_0008, 32'h0,         4'hF, -1, 32'h9999_9999, 1, 1'b0, 16'd8, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 32'h3000_000C, 32'h0,         4'h3, 7,  32'hCAFE_F00D, 5, 1'b1, 16'd8, 1'b0, 32'hCAFE_F00D};
    vecs[4] = '{1'b1, 32'h3000_0010, 32'h0102_0304, 4'h1, 7,  32'hFFFF_FFFF, 2, 1'b1, 16'd8, 1'b0, 32'h0};
    vecs[5] = '{1'b1, 32'h3000_0014, 32'h0506_0708, 4'hC, -1, 32'h0,         0, 1'b0, 16'd8, 1'b1, 32'h0};

    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 64'(bus.cmd_ready_o), 64'd1);
    check("rst_rsp", 64'({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_dat_o}), 64'd0);
    check("rst_wbm", 64'({bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o}), 64'd0);
    check("rst_wbm_adr_dat", 64'({bus.wbm_adr_o, bus.wbm_dat_o}), 64'd0);
    rst_n = 1'b1;

    // stray ACK while idle
    bus.wbm_ack_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_ack_ignored", 64'({bus.rsp_valid_o, bus.wbm_cyc_o, bus.cmd_ready_o}), 64'b001);
    end
    bus.wbm_ack_i = 1'b0;

    // directed table
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({vecs[i].exp_err, vecs[i].exp_dat, vecs[i].exp_len});
      run_txn(vecs[i]);
    end

    // reset during the second BUS cycle
    @(negedge clk);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_adr_i   = 32'h3000_0040;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    check("rst5_bus0", 64'(bus.wbm_cyc_o), 64'd1);
    @(negedge clk);
    check("rst5_bus1", 64'(bus.wbm_cyc_o), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst5_drop", 64'({bus.wbm_cyc_o, bus.wbm_stb_o, bus.rsp_valid_o, bus.cmd_ready_o}), 64'b0001);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst5_quiet", 64'({bus.wbm_cyc_o, bus.rsp_valid_o, bus.cmd_ready_o}), 64'b001);
    end

    // back-to-back: second command waits for the first response handshake
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_adr_i   = 32'h3000_0050;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_we_i    = 1'b1;
    bus.cmd_adr_i   = 32'h3000_0060;
    bus.cmd_dat_i   = 32'h1122_3344;
    bus.cmd_sel_i   = 4'h3;
    check("b2b_a_adr", 64'({bus.wbm_cyc_o, bus.wbm_adr_o}), 64'({1'b1, 32'h3000_0050}));
    bus.wbm_ack_i = 1'b1;
    bus.wbm_dat_i = 32'h5566_7788;
    @(negedge clk);
    check("b2b_a_rsp", 64'({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_dat_o}), 64'({2'b10, 32'h5566_7788}));
    repeat (3) begin
      @(negedge clk);
      check("b2b_a_hold", 64'({bus.rsp_valid_o, bus.cmd_ready_o, bus.wbm_cyc_o, bus.rsp_dat_o}),
            64'({3'b100, 32'h5566_7788}));
    end
    bus.wbm_ack_i   = 1'b0;
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    check("b2b_idle", 64'({bus.rsp_valid_o, bus.cmd_ready_o, bus.wbm_cyc_o}), 64'b010);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    check("b2b_b_bus", 64'({bus.wbm_cyc_o, bus.wbm_we_o, bus.wbm_sel_o, bus.wbm_adr_o}),
          64'({2'b11, 4'h3, 32'h3000_0060}));
    check("b2b_b_dat", 64'(bus.wbm_dat_o), 64'h1122_3344);
    bus.wbm_ack_i = 1'b1;
    @(negedge clk);
    bus.wbm_ack_i = 1'b0;
    check("b2b_b_rsp", 64'({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_dat_o}), 64'({2'b10, 32'h0}));
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    check("b2b_b_done", 64'({bus.rsp_valid_o, bus.cmd_ready_o}), 64'b01);

    // random transactions against the model
    for (int n = 0; n < 40; n++) begin
      int r;
      v.we       = 1'($urandom_range(0, 1));
      v.adr      = 32'($urandom);
      v.dat      = 32'($urandom);
      v.sel      = 4'($urandom_range(0, 15));
      r          = int'($urandom_range(0, 10));
      v.ack_k    = (r == 10) ? -1 : r;
      v.rdata    = 32'($urandom);
      v.rsp_wait = int'($urandom_range(0, 3));
      v.stray    = 1'($urandom_range(0, 1));
      exp_q.push_back(model(v.we, v.ack_k, v.rdata));
      run_txn(v);
    end

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
